// File: rtl/phy_tx_sched.sv
// phy_tx_sched: round-robin 4-requester to 2-lane PHY TX scheduler; comma INIT phase built only with TX_SCHED_INIT_EN
module phy_tx_sched #(
  parameter int         INIT_CYCLES = 16,
  parameter logic [7:0] COMMA       = 8'hBC
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic        tx_en,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ready,
  output logic [7:0]  data_out0,
  output logic [7:0]  data_out1,
  output logic        valid_out0,
  output logic        valid_out1,
  output logic [1:0]  state
);
  localparam logic [1:0] S_INIT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  logic [1:0] state_q, state_d, ptr_q, ptr_d, g0, g1, idx;
  logic [7:0] d0_q, d0_d, d1_q, d1_d;
  logic       v0_q, v0_d, v1_q, v1_d, h0, h1, grant_en;
`ifdef TX_SCHED_INIT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       last;
  assign last = cnt_q == 8'(INIT_CYCLES - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{COMMA, INIT_CYCLES[7:0]};
`endif
  assign grant_en = reset && state_q == S_RUN && tx_en;
  always_comb begin
    g0 = '0;
    g1 = '0;
    h0 = 1'b0;
    h1 = 1'b0;
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (req_valid[idx] && !h0) begin
        g0 = idx;
        h0 = 1'b1;
      end else if (req_valid[idx] && !h1) begin
        g1 = idx;
        h1 = 1'b1;
      end
    end
  end
  assign req_ready = grant_en ? ((h0 ? 4'b0001 << g0 : 4'b0000) | (h1 ? 4'b0001 << g1 : 4'b0000)) : 4'b0000;
  always_comb begin
    state_d = S_RUN;
    ptr_d = ptr_q;
    d0_d = 8'h00;
    d1_d = 8'h00;
    v0_d = 1'b0;
    v1_d = 1'b0;
`ifdef TX_SCHED_INIT_EN
    cnt_d = cnt_q;
`endif
    if (state_q == S_RUN) begin
      state_d = tx_en ? S_RUN : S_HOLD;
      d0_d = grant_en && h0 ? req_data[{g0, 3'b000} +: 8] : 8'h00;
      d1_d = grant_en && h1 ? req_data[{g1, 3'b000} +: 8] : 8'h00;
      v0_d = grant_en && h0;
      v1_d = grant_en && h1;
      ptr_d = !grant_en ? ptr_q : h1 ? g1 + 2'd1 : h0 ? g0 + 2'd1 : ptr_q;
    end else if (state_q == S_HOLD) begin
      state_d = tx_en ? S_RUN : S_HOLD;
`ifdef TX_SCHED_INIT_EN
    end else if (state_q == S_INIT) begin
      state_d = last ? S_RUN : S_INIT;
      cnt_d = last ? 8'd0 : cnt_q + 8'd1;
      d0_d = COMMA;
      d1_d = COMMA;
      v0_d = 1'b1;
      v1_d = 1'b1;
`endif
    end
  end
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
`ifdef TX_SCHED_INIT_EN
      state_q <= S_INIT;
      cnt_q <= 8'd0;
`else
      state_q <= S_RUN;
`endif
      ptr_q <= 2'd0;
      d0_q <= 8'h00;
      d1_q <= 8'h00;
      v0_q <= 1'b0;
      v1_q <= 1'b0;
    end else begin
`ifdef TX_SCHED_INIT_EN
      cnt_q <= cnt_d;
`endif
      state_q <= state_d;
      ptr_q <= ptr_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      v0_q <= v0_d;
      v1_q <= v1_d;
    end
  end
  assign data_out0 = d0_q;
  assign data_out1 = d1_q;
  assign valid_out0 = v0_q;
  assign valid_out1 = v1_q;
  assign state = state_q;
endmodule

// File: tb/tb_phy_tx_sched.sv
// tb_phy_tx_sched: randomized bench for phy_tx_sched against a queue-based reference model
module tb_phy_tx_sched;
  localparam int IC = 4;
  logic        clk_2f = 1'b0;
  logic        reset = 1'b1;
  logic        tx_en = 1'b0;
  logic [3:0]  req_valid = 4'h0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ready;
  logic [7:0]  data_out0, data_out1;
  logic        valid_out0, valid_out1;
  logic [1:0]  state;
  int errs = 0;
  int checks = 0;
  int m_mode, m_ptr, m_left;
  logic [7:0] m_d0, m_d1;
  logic m_v0, m_v1;
  always #5 clk_2f = ~clk_2f;
  phy_tx_sched #(.INIT_CYCLES(IC), .COMMA(8'hBC)) dut (
    .clk_2f(clk_2f), .reset(reset), .tx_en(tx_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .data_out0(data_out0), .data_out1(data_out1),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .state(state)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_ptr = 0;
    m_d0 = 8'h00;
    m_d1 = 8'h00;
    m_v0 = 1'b0;
    m_v1 = 1'b0;
    m_left = IC;
`ifdef TX_SCHED_INIT_EN
    m_mode = 0;
`else
    m_mode = 1;
`endif
  endtask
  task automatic chk_out(input string tag);
    chk({tag, "_d0"}, data_out0, m_d0);
    chk({tag, "_v0"}, valid_out0, m_v0);
    chk({tag, "_d1"}, data_out1, m_d1);
    chk({tag, "_v1"}, valid_out1, m_v1);
    chk({tag, "_state"}, state, m_mode);
  endtask
  // Called at posedge+1: apply inputs, check grants, advance one edge, check lanes.
  task automatic cycle(input logic en, input logic [3:0] v, input logic [31:0] d);
    int g[$];
    logic [3:0] rdy;
    tx_en = en;
    req_valid = v;
    req_data = d;
    #1;
    g = {};
    rdy = 4'h0;
    if (m_mode == 1 && en)
      for (int k = 0; k < 4; k++)
        if (v[(m_ptr + k) % 4] && g.size() < 2) g.push_back((m_ptr + k) % 4);
    foreach (g[j]) rdy[g[j]] = 1'b1;
    chk("ready", req_ready, rdy);
    @(posedge clk_2f);
    m_d0 = 8'h00;
    m_d1 = 8'h00;
    m_v0 = 1'b0;
    m_v1 = 1'b0;
    if (m_mode == 0) begin
      m_d0 = 8'hBC;
      m_d1 = 8'hBC;
      m_v0 = 1'b1;
      m_v1 = 1'b1;
      m_left--;
      if (m_left == 0) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!en) m_mode = 2;
      else begin
        if (g.size() > 0) begin
          m_d0 = d[8 * g[0] +: 8];
          m_v0 = 1'b1;
          m_ptr = (g[g.size() - 1] + 1) % 4;
        end
        if (g.size() > 1) begin
          m_d1 = d[8 * g[1] +: 8];
          m_v1 = 1'b1;
        end
      end
    end else if (en) m_mode = 1;
    #1;
    chk_out("out");
  endtask
  task automatic mid_reset();
    reset = 1'b0;
    #1;
    m_reset();
    chk("rst_ready", req_ready, 4'h0);
    chk_out("rst");
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b1;
  endtask
  initial begin
    m_reset();
    #2 reset = 1'b0;
    #1;
    chk("por_ready", req_ready, 4'h0);
    chk_out("por");
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'hF, 32'h44332211);
    for (int i = 0; i < IC + 2; i++) cycle(1'b1, 4'b0000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0100, 32'h00A50000);
      chk("single_d0", data_out0, 8'hA5);
      chk("single_v1", valid_out1, 1'b0);
    end
    cycle(1'b1, 4'b1001, 32'h33000011);
    chk("fair_d0", data_out0, 8'h33);
    chk("fair_d1", data_out1, 8'h11);
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'hF, 32'h44332211);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'hF, 32'h44332211);
    for (int i = 0; i < 4; i++) cycle(1'b1, 4'hF, 32'h44332211);
    mid_reset();
    for (int i = 0; i < IC + 3; i++) cycle(1'b1, 4'hF, 32'h44332211);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) mid_reset();
      cycle($urandom_range(0, 7) != 0, 4'($urandom), $urandom);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
